uart_frame_tx: RTL and testbench

//  Parametrised multi-byte UART frame transmitter with its own 8N1 bit serialiser.
//  On a start pulse it captures an NBYTES-wide word, sends it back-to-back as NBYTES

---
 rtl/uart_frame_tx_if.sv | 23 ++
 rtl/uart_frame_tx.sv | 133 +++++++++++++
 tb/tb_uart_frame_tx.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_tx_if.sv
// Bus bundle for uart_frame_tx: start/payload request in, serial line and status out.
// Handshake: trans_go is sampled on every posedge while busy=0 and is ignored while busy=1.
interface uart_frame_tx_if #(
  parameter int NBYTES = 5
) ();
  logic                  trans_go;
  logic [NBYTES*8-1:0]   data;
  logic                  uart_tx;
  logic                  busy;
  logic                  byte_done;
  logic                  all_done;
  logic [1:0]            dbg_state;

  modport master (
    output trans_go, data,
    input  uart_tx, busy, byte_done, all_done, dbg_state
  );

  modport slave (
    input  trans_go, data,
    output uart_tx, busy, byte_done, all_done, dbg_state
  );
endinterface

// File: rtl/uart_frame_tx.sv
// Multi-byte 8N1 UART frame transmitter: captures an NBYTES word on trans_go and sends it back-to-back.
// Define FRAME_CHECKSUM_EN to append one XOR checksum byte after the payload.
module uart_frame_tx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int NBYTES    = 5,
  parameter bit MSB_FIRST = 1'b0
) (
  input logic            sys_clk,
  input logic            rst_n,
  uart_frame_tx_if.slave bus
);
  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int BW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int CW       = $clog2(NBYTES + 2);
`ifdef FRAME_CHECKSUM_EN
  localparam int NTX      = NBYTES + 1;
`else
  localparam int NTX      = NBYTES;
`endif
  localparam int SW       = NTX * 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [CW-1:0]   byte_q, byte_d;
  logic [SW-1:0]   sh_q, sh_d;
  logic            byte_done_q, byte_done_d;
  logic            all_done_q, all_done_d;
  logic [SW-1:0]   load_w;
  logic            bit_end_w;

  // The shift register is loaded in transmit order, so byte 0 on the line always sits in the low bits.
  always_comb begin
    load_w = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (MSB_FIRST) load_w[i*8 +: 8] = bus.data[(NBYTES-1-i)*8 +: 8];
      else           load_w[i*8 +: 8] = bus.data[i*8 +: 8];
    end
`ifdef FRAME_CHECKSUM_EN
    for (int i = 0; i < NBYTES; i++) begin
      load_w[NBYTES*8 +: 8] = load_w[NBYTES*8 +: 8] ^ bus.data[i*8 +: 8];
    end
`endif
  end

  assign bit_end_w = (baud_q == BW'(BAUD_DIV - 1));

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    byte_d      = byte_q;
    sh_d        = sh_q;
    byte_done_d = 1'b0;
    all_done_d  = 1'b0;
    if (state_q != S_IDLE) begin
      baud_d = bit_end_w ? '0 : baud_q + BW'(1);
    end
    case (state_q)
      S_IDLE: begin
        if (bus.trans_go) begin
          state_d = S_START;
          baud_d  = '0;
          bit_d   = '0;
          byte_d  = '0;
          sh_d    = load_w;
        end
      end
      S_START: begin
        if (bit_end_w) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end_w) begin
          sh_d = sh_q >> 1;
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      S_STOP: begin
        if (bit_end_w) begin
          byte_done_d = 1'b1;
          byte_d      = byte_q + CW'(1);
          if (byte_q == CW'(NTX - 1)) begin
            state_d    = S_IDLE;
            all_done_d = 1'b1;
          end else begin
            state_d    = S_START;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      byte_q      <= '0;
      sh_q        <= '0;
      byte_done_q <= 1'b0;
      all_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      byte_q      <= byte_d;
      sh_q        <= sh_d;
      byte_done_q <= byte_done_d;
      all_done_q  <= all_done_d;
    end
  end

  // Line level decoded from registered state only, so reset drives it high asynchronously.
  assign bus.uart_tx   = (state_q == S_START) ? 1'b0 :
                         (state_q == S_DATA)  ? sh_q[0] : 1'b1;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.byte_done = byte_done_q;
  assign bus.all_done  = all_done_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_uart_frame_tx.sv
// Self-checking bench for uart_frame_tx: two instances (LSB-first and MSB-first byte order)
// checked cycle by cycle against an arithmetic frame model and a decoded-byte scoreboard.
module tb_uart_frame_tx;
  localparam int CLK_FREQ  = 1000;
  localparam int BAUD      = 100;
  localparam int DIV       = CLK_FREQ / BAUD;
  localparam int NB        = 5;
  localparam int W         = NB * 8;
`ifdef FRAME_CHECKSUM_EN
  localparam int NTX       = NB + 1;
`else
  localparam int NTX       = NB;
`endif
  localparam int BYTE_CYC  = 10 * DIV;
  localparam int FRAME_CYC = NTX * BYTE_CYC;

  logic       sys_clk = 1'b0;
  logic       rst_n   = 1'b0;
  int         n_vec   = 0;
  int         n_err   = 0;
  logic [7:0] exp_q[$];

  uart_frame_tx_if #(.NBYTES(NB)) bus0 ();
  uart_frame_tx_if #(.NBYTES(NB)) bus1 ();

  uart_frame_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .NBYTES(NB), .MSB_FIRST(1'b0)) dut0 (
    .sys_clk(sys_clk), .rst_n(rst_n), .bus(bus0)
  );
  uart_frame_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .NBYTES(NB), .MSB_FIRST(1'b1)) dut1 (
    .sys_clk(sys_clk), .rst_n(rst_n), .bus(bus1)
  );

  // ---------------- clock / reset ----------------
  always #5 sys_clk = ~sys_clk;

  // ---------------- driver tasks ----------------
  task automatic set_go(input bit sel, input logic v);
    if (sel) bus1.trans_go = v;
    else     bus0.trans_go = v;
  endtask

  task automatic set_data(input bit sel, input logic [W-1:0] d);
    if (sel) bus1.data = d;
    else     bus0.data = d;
  endtask

  task automatic sample(input bit sel, output logic tx, output logic bz,
                        output logic bd, output logic ad);
    if (sel) begin
      tx = bus1.uart_tx; bz = bus1.busy; bd = bus1.byte_done; ad = bus1.all_done;
    end else begin
      tx = bus0.uart_tx; bz = bus0.busy; bd = bus0.byte_done; ad = bus0.all_done;
    end
  endtask

  task automatic start_frame(input bit sel, input logic [W-1:0] d, input bit hold);
    @(posedge sys_clk); #1;
    set_data(sel, d);
    set_go(sel, 1'b1);
    @(posedge sys_clk); #1;
    if (!hold) set_go(sel, 1'b0);
  endtask

  // Checks one whole frame starting at the first busy cycle, through the all_done cycle.
  task automatic check_frame(input bit sel, input logic [W-1:0] d,
                             input int new_data_at, input logic [W-1:0] d_new,
                             input int drop_go_at);
    logic [7:0] fb[NTX];
    logic [7:0] cks;
    logic [7:0] rx;
    logic [7:0] e;
    logic tx, bz, bd, ad, etx, ebz, ebd, ead;
    int e_tx, e_bz, e_bd, e_ad, idx, bitpos, b, j;
    e_tx = 0; e_bz = 0; e_bd = 0; e_ad = 0;
    cks = 8'h00;
    rx  = 8'h00;
    j   = 0;
    for (int i = 0; i < NB; i++) begin
      idx   = sel ? (NB - 1 - i) : i;
      fb[i] = d[idx*8 +: 8];
      cks   = cks ^ fb[i];
      exp_q.push_back(fb[i]);
    end
`ifdef FRAME_CHECKSUM_EN
    fb[NB] = cks;
    exp_q.push_back(cks);
`endif
    for (int k = 0; k <= FRAME_CYC; k++) begin
      @(negedge sys_clk);
      sample(sel, tx, bz, bd, ad);
      if (k < FRAME_CYC) begin
        bitpos = k / DIV;
        b      = bitpos / 10;
        j      = bitpos % 10;
        etx    = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : fb[b][j-1];
        ebz    = 1'b1;
      end else begin
        etx = 1'b1;
        ebz = 1'b0;
      end
      ebd = (k > 0) && (k % BYTE_CYC == 0);
      ead = (k == FRAME_CYC);
      if (tx !== etx) e_tx++;
      if (bz !== ebz) e_bz++;
      if (bd !== ebd) e_bd++;
      if (ad !== ead) e_ad++;
      if (k < FRAME_CYC && (k % DIV) == DIV / 2) begin
        if (j >= 1 && j <= 8) rx[j-1] = tx;
        if (j == 9) begin
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL rx_byte: got %02h but scoreboard is empty", rx);
          end else begin
            e = exp_q.pop_front();
            if (rx !== e) begin
              n_err++;
              $display("FAIL rx_byte: dut%0d byte %0d got %02h expected %02h", sel, b, rx, e);
            end
          end
        end
      end
      if (k == new_data_at) set_data(sel, d_new);
      if (k == drop_go_at)  set_go(sel, 1'b0);
    end
    n_vec++;
    if (e_tx !== 0) begin n_err++; $display("FAIL line_wave: dut%0d %0d bad cycles expected 0", sel, e_tx); end
    n_vec++;
    if (e_bz !== 0) begin n_err++; $display("FAIL busy_wave: dut%0d %0d bad cycles expected 0", sel, e_bz); end
    n_vec++;
    if (e_bd !== 0) begin n_err++; $display("FAIL byte_done_wave: dut%0d %0d bad cycles expected 0", sel, e_bd); end
    n_vec++;
    if (e_ad !== 0) begin n_err++; $display("FAIL all_done_wave: dut%0d %0d bad cycles expected 0", sel, e_ad); end
  endtask

  // Counts cycles where either instance is not in the quiet idle state.
  task automatic check_idle(input int cycles, input string name);
    logic tx, bz, bd, ad;
    int bad;
    bad = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge sys_clk);
      for (int s = 0; s < 2; s++) begin
        sample(s[0], tx, bz, bd, ad);
        if (tx !== 1'b1 || bz !== 1'b0 || bd !== 1'b0 || ad !== 1'b0) bad++;
      end
    end
    n_vec++;
    if (bad !== 0) begin n_err++; $display("FAIL %s: %0d bad samples expected 0", name, bad); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic tx, bz, bd, ad;
    bus0.trans_go = 1'b0; bus1.trans_go = 1'b0;
    bus0.data = '0;       bus1.data = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    for (int s = 0; s < 2; s++) begin
      sample(s[0], tx, bz, bd, ad);
      n_vec++;
      if ({tx, bz, bd, ad} !== 4'b1000) begin
        n_err++;
        $display("FAIL reset_state: dut%0d tx/busy/bd/ad=%b expected 1000", s, {tx, bz, bd, ad});
      end
    end
    rst_n = 1'b1;
    check_idle(50, "idle_after_reset");
  endtask

  task automatic test_lsb_first();
    start_frame(1'b0, 40'h5544332211, 1'b0);
    check_frame(1'b0, 40'h5544332211, -1, '0, -1);
  endtask

  task automatic test_msb_first();
    start_frame(1'b1, 40'h5544332211, 1'b0);
    check_frame(1'b1, 40'h5544332211, -1, '0, -1);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] d1, d2;
    d1 = {$urandom, $urandom};
    d2 = ~d1;
    start_frame(1'b0, d1, 1'b1);
    check_frame(1'b0, d1, 2 * BYTE_CYC, d2, -1);
    check_frame(1'b0, d2, -1, '0, 0);
    check_idle(20, "idle_after_chain");
  endtask

  task automatic test_reset_abort();
    logic tx, bz, bd, ad;
    logic [W-1:0] d;
    int bad;
    bad = 0;
    d = {$urandom, $urandom};
    start_frame(1'b0, d, 1'b0);
    repeat (BYTE_CYC + BYTE_CYC / 2) @(negedge sys_clk);
    rst_n = 1'b0;
    #1;
    sample(1'b0, tx, bz, bd, ad);
    n_vec++;
    if (tx !== 1'b1 || bz !== 1'b0) begin
      n_err++;
      $display("FAIL abort_async: tx=%b busy=%b expected tx=1 busy=0", tx, bz);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge sys_clk);
      sample(1'b0, tx, bz, bd, ad);
      if ({tx, bz, bd, ad} !== 4'b1000) bad++;
    end
    n_vec++;
    if (bad !== 0) begin n_err++; $display("FAIL abort_hold: %0d bad cycles expected 0", bad); end
    rst_n = 1'b1;
    check_idle(FRAME_CYC + 20, "no_resume_after_abort");
    d = {$urandom, $urandom};
    start_frame(1'b0, d, 1'b0);
    check_frame(1'b0, d, -1, '0, -1);
  endtask

  task automatic test_random();
    logic [W-1:0] d;
    bit sel;
    for (int n = 0; n < 4; n++) begin
      sel = 1'($urandom_range(0, 1));
      d   = {$urandom, $urandom};
      repeat ($urandom_range(0, 20)) @(posedge sys_clk);
      start_frame(sel, d, 1'b0);
      check_frame(sel, d, -1, '0, -1);
    end
  endtask

  task automatic test_checksum();
    start_frame(1'b0, 40'h0F0F0F0F01, 1'b0);
    check_frame(1'b0, 40'h0F0F0F0F01, -1, '0, -1);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_back_to_back();
    test_reset_abort();
    test_random();
    test_checksum();
    n_vec++;
    if (exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d bytes left expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
